// File: rtl/filt_window_fetch_if.sv
// Fetcher-side bundle: frame control, pixel-memory read/write ports and the median filter handshake.
// master = the window fetcher; slave = the environment (memory + filter + frame controller).
interface filt_window_fetch_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 16
);
    logic                  start;
    logic                  busy;
    logic                  frame_done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  filt_en;
    logic                  pix_rdy;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  filt_done;
    logic [DATA_WIDTH-1:0] filt_res;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  start, rd_data, filt_done, filt_res,
        output busy, frame_done, rd_en, rd_addr, filt_en, pix_rdy, pix_data,
               wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data, filt_done, filt_res,
        input  busy, frame_done, rd_en, rd_addr, filt_en, pix_rdy, pix_data,
               wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/filt_window_fetch.sv
// Scans the image row-major, streams each clamped window to the median filter (4 cycles/tap),
// waits for the filter's done without timeout, then writes the result; all outputs registered.
module filt_window_fetch #(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 16,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int WINDOW_SIZE = 3,
    parameter int IN_BASE     = 0,
    parameter int OUT_BASE    = 256
) (
    input  logic                Filt_CLK,
    input  logic                Filt_RST,
    filt_window_fetch_if.master bus
);
    localparam int R    = WINDOW_SIZE / 2;
    localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW   = $clog2(MAXD) + 2;
    localparam int TW   = $clog2(WINDOW_SIZE + 1);

    localparam logic signed [CW-1:0] XMAX  = CW'(IMG_W - 1);
    localparam logic signed [CW-1:0] YMAX  = CW'(IMG_H - 1);
    localparam logic signed [CW-1:0] RS    = CW'(R);
    localparam logic        [TW-1:0] TLAST = TW'(WINDOW_SIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_ADDR, S_WAIT, S_PRES, S_DROP, S_WDONE, S_WRITE, S_NEXT
    } state_t;

    state_t                 state_q, state_d;
    logic signed [CW-1:0]   x_q, x_d, y_q, y_d;
    logic        [TW-1:0]   tap_x_q, tap_x_d, tap_y_q, tap_y_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                   filt_en_q, filt_en_d;
    logic                   pix_rdy_q, pix_rdy_d;
    logic [DATA_WIDTH-1:0]  pix_data_q, pix_data_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic signed [CW-1:0]   cx, cy;

    // Edge replication: out-of-image taps snap to the nearest border pixel.
    function automatic logic signed [CW-1:0] clamp(input logic signed [CW-1:0] v,
                                                   input logic signed [CW-1:0] hi);
        if (v[CW-1])
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        tap_x_d      = tap_x_q;
        tap_y_d      = tap_y_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        rd_addr_d    = rd_addr_q;
        pix_data_d   = pix_data_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_ARM;
                end
            end
            S_ARM:  state_d = S_ADDR;
            S_ADDR: state_d = S_WAIT;
            S_WAIT: begin
                pix_data_d = bus.rd_data;
                state_d    = S_PRES;
            end
            S_PRES: state_d = S_DROP;
            S_DROP: begin
                // Tap counters return to zero after the last tap, ready for the next window.
                if (tap_x_q == TLAST) begin
                    tap_x_d = '0;
                    if (tap_y_q == TLAST) begin
                        tap_y_d = '0;
                        state_d = S_WDONE;
                    end else begin
                        tap_y_d = tap_y_q + TW'(1);
                        state_d = S_ADDR;
                    end
                end else begin
                    tap_x_d = tap_x_q + TW'(1);
                    state_d = S_ADDR;
                end
            end
            S_WDONE: begin
                if (bus.filt_done) begin
                    wr_data_d = bus.filt_res;
                    wr_addr_d = ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(y_q) * ADDR_WIDTH'(IMG_W)
                              + ADDR_WIDTH'(x_q);
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (x_q == XMAX) begin
                    x_d = '0;
                    if (y_q == YMAX) begin
                        y_d          = '0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        y_d     = y_q + CW'(1);
                        state_d = S_ARM;
                    end
                end else begin
                    x_d     = x_q + CW'(1);
                    state_d = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cx = clamp(x_q + $signed(CW'(tap_x_d)) - RS, XMAX);
        cy = clamp(y_q + $signed(CW'(tap_y_d)) - RS, YMAX);

        // Outputs are decoded from the next state so they line up with state_q when registered.
        rd_en_d   = (state_d == S_ADDR);
        pix_rdy_d = (state_d == S_PRES);
        wr_en_d   = (state_d == S_WRITE);
        filt_en_d = (state_d == S_ARM)  || (state_d == S_ADDR) || (state_d == S_WAIT) ||
                    (state_d == S_PRES) || (state_d == S_DROP) || (state_d == S_WDONE);
        if (state_d == S_ADDR)
            rd_addr_d = ADDR_WIDTH'(IN_BASE) + ADDR_WIDTH'(cy) * ADDR_WIDTH'(IMG_W)
                      + ADDR_WIDTH'(cx);
    end

    always_ff @(posedge Filt_CLK or posedge Filt_RST) begin
        if (Filt_RST) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            tap_x_q      <= '0;
            tap_y_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            filt_en_q    <= 1'b0;
            pix_rdy_q    <= 1'b0;
            pix_data_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tap_x_q      <= tap_x_d;
            tap_y_q      <= tap_y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            filt_en_q    <= filt_en_d;
            pix_rdy_q    <= pix_rdy_d;
            pix_data_q   <= pix_data_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.filt_en    = filt_en_q;
    assign bus.pix_rdy    = pix_rdy_q;
    assign bus.pix_data   = pix_data_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_filt_window_fetch.sv
// Bench for filt_window_fetch on a 4x4 image: 1-cycle memory, behavioural median filter,
// write scoreboard fed by the stimulus and drained by an independent monitor.
`timescale 1ns/1ps
module tb_filt_window_fetch;
    localparam int DW = 24;
    localparam int AW = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WS = 3;
    localparam int OB = 256;
    localparam int TAPS = WS * WS;

    logic Filt_CLK = 1'b0;
    logic Filt_RST = 1'b1;
    always #5 Filt_CLK = ~Filt_CLK;

    filt_window_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    filt_window_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H),
        .WINDOW_SIZE(WS), .IN_BASE(0), .OUT_BASE(OB)
    ) dut (
        .Filt_CLK (Filt_CLK),
        .Filt_RST (Filt_RST),
        .bus      (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            applied = 0;
    int            miscompares = 0;
    int            rd_cnt = 0, rdy_cnt = 0, en_rise = 0, wr_cnt = 0, fd_cnt = 0, wdone_viol = 0;
    logic [AW-1:0] rd_hist [4096];
    logic          en_prev_m = 1'b0;
    logic [AW-1:0] corner_seq [9] = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd4, 16'd4, 16'd5};

    // ---------------- memory model: data one cycle after rd_en ----------------
    logic [DW-1:0] mem [512];
    always @(posedge Filt_CLK)
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[8:0]];

    // ---------------- behavioural median filter ----------------
    int            done_delay = 1;
    int            f_cnt, f_dly;
    logic          f_en_prev, f_rdy_prev;
    logic [DW-1:0] f_samp [9];

    function automatic logic [DW-1:0] median9();
        logic [DW-1:0] a [9];
        logic [DW-1:0] t;
        for (int i = 0; i < 9; i++) a[i] = f_samp[i];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    always @(posedge Filt_CLK or posedge Filt_RST) begin
        if (Filt_RST) begin
            f_en_prev     <= 1'b0;
            f_rdy_prev    <= 1'b0;
            f_cnt         <= 0;
            f_dly         <= 0;
            bus.filt_done <= 1'b0;
            bus.filt_res  <= '0;
        end else begin
            f_en_prev  <= bus.filt_en;
            f_rdy_prev <= bus.pix_rdy;
            if (!bus.filt_en) begin
                bus.filt_done <= 1'b0;
                f_cnt         <= 0;
            end else if (!f_en_prev) begin
                bus.filt_done <= 1'b0;
                f_cnt         <= 0;
            end else if (f_rdy_prev && !bus.pix_rdy && f_cnt < TAPS) begin
                f_samp[f_cnt] <= bus.pix_data;
                f_cnt         <= f_cnt + 1;
                f_dly         <= done_delay;
            end else if (f_cnt == TAPS && !bus.filt_done) begin
                if (f_dly == 0) begin
                    bus.filt_done <= 1'b1;
                    bus.filt_res  <= median9();
                end else begin
                    f_dly <= f_dly - 1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge Filt_CLK) begin
        if (bus.rd_en) begin
            if (rd_cnt < 4096) rd_hist[rd_cnt] = bus.rd_addr;
            rd_cnt++;
        end
        if (bus.pix_rdy) rdy_cnt++;
        if (bus.filt_en && !en_prev_m) en_rise++;
        en_prev_m = bus.filt_en;
        if (bus.frame_done) fd_cnt++;
        if (f_cnt == TAPS && (bus.rd_en || bus.pix_rdy)) wdone_viol++;
        if (bus.wr_en) begin
            wr_cnt++;
            applied++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.wr_addr !== mon_e.addr || bus.wr_data !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL wr_scoreboard: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.wr_addr, bus.wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint req);
        applied++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Filt_CLK);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge Filt_CLK);
        bus.start = 1'b0;
    endtask

    // Image modes: 0 constant, 1 single bright pixel, 2 row ramp, 3 column ramp.
    function automatic logic [DW-1:0] pix_val(input int mode, input int xx, input int yy);
        case (mode)
            0:       return 24'h123456;
            1:       return (xx == 1 && yy == 1) ? 24'hFFFFFF : 24'h000000;
            2:       return DW'(yy) * 24'h010101;
            default: return DW'(xx) * 24'h0A0B0C;
        endcase
    endfunction

    // Hand-derived medians: a ramp's 3x3 median is the centre's ramp value,
    // a lone bright pixel never reaches the median.
    function automatic logic [DW-1:0] exp_val(input int mode, input int xx, input int yy);
        case (mode)
            0:       return 24'h123456;
            1:       return 24'h000000;
            2:       return DW'(yy) * 24'h010101;
            default: return DW'(xx) * 24'h0A0B0C;
        endcase
    endfunction

    task automatic load_image(input int mode);
        for (int i = 0; i < 512; i++) mem[i] = '0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                mem[yy*W + xx] = pix_val(mode, xx, yy);
    endtask

    task automatic push_expected(input int mode);
        wr_t e;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                e.addr = AW'(OB + yy*W + xx);
                e.data = exp_val(mode, xx, yy);
                exp_q.push_back(e);
            end
    endtask

    task automatic run_frame(input string name, input int mode, input int delay, input logic repulse);
        int rd0, rdy0, en0, wr0, fd0, viol0, n;
        load_image(mode);
        push_expected(mode);
        done_delay = delay;
        rd0 = rd_cnt; rdy0 = rdy_cnt; en0 = en_rise; wr0 = wr_cnt; fd0 = fd_cnt; viol0 = wdone_viol;
        pulse_start();
        check({name, "_busy_set"}, bus.busy, 1);
        n = 0;
        while (fd_cnt == fd0 && n < 3000) begin
            @(negedge Filt_CLK);
            n++;
            if (repulse && (n == 50 || n == 300)) begin
                pulse_start();
                n++;
            end
        end
        if (fd_cnt == fd0) begin
            applied++;
            miscompares++;
            $display("FAIL %s_timeout: got no frame_done after %0d cycles, required one", name, n);
        end
        tick(3);
        check({name, "_busy_clr"},   bus.busy, 0);
        check({name, "_rd_count"},   rd_cnt - rd0, W*H*TAPS);
        check({name, "_rdy_pulses"}, rdy_cnt - rdy0, W*H*TAPS);
        check({name, "_en_rises"},   en_rise - en0, W*H);
        check({name, "_writes"},     wr_cnt - wr0, W*H);
        check({name, "_frame_done"}, fd_cnt - fd0, 1);
        check({name, "_wdone_idle"}, wdone_viol - viol0, 0);
        for (int i = 0; i < 9; i++)
            if (rd0 + i < 4096)
                check($sformatf("%s_rd_addr%0d", name, i), rd_hist[rd0 + i], corner_seq[i]);
    endtask

    function automatic logic any_output();
        return |{bus.busy, bus.frame_done, bus.rd_en, bus.rd_addr, bus.filt_en, bus.pix_rdy,
                 bus.pix_data, bus.wr_en, bus.wr_addr, bus.wr_data};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int rd0, wr0, n;
        bus.start = 1'b0;
        tick(3);
        check("reset_outputs", any_output(), 0);
        Filt_RST = 1'b0;
        tick(2);

        run_frame("const",     0, 1,  1'b1);
        run_frame("spot",      1, 1,  1'b0);
        run_frame("rows",      2, 1,  1'b0);
        run_frame("cols_slow", 3, 20, 1'b0);

        // Abort mid-window (5th tap) with an asynchronous reset, then restart cleanly.
        load_image(2);
        done_delay = 1;
        rd0 = rd_cnt;
        pulse_start();
        n = 0;
        while (rd_cnt < rd0 + 5 && n < 200) begin
            @(negedge Filt_CLK);
            n++;
        end
        check("abort_reached_tap5", (rd_cnt >= rd0 + 5) ? 1 : 0, 1);
        #2 Filt_RST = 1'b1;
        #1;
        check("abort_outputs_zero", any_output(), 0);
        check("abort_busy", bus.busy, 0);
        wr0 = wr_cnt;
        tick(3);
        Filt_RST = 1'b0;
        tick(30);
        check("abort_no_write", wr_cnt - wr0, 0);
        check("abort_idle", bus.filt_en, 0);
        run_frame("restart", 2, 1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
